rot_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 8-bit barrel rotator between two requesters. Each requester issues a rotate command (data, amount, direction) through a valid/ready handshake. The block grants one command at a time, drives the shared rotator from registered operands, captures the result, and returns it with the requester ID through a response handshake that honours backpressure. The rotator itself sits outside this block, wired to the `rot_*` ports.

---
 rtl/rot_arbiter.sv | 122 ++++++++++++
 tb/tb_rot_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_arbiter.sv
// rot_arbiter: round-robin arbiter and sequencer that shares one external
// 8-bit barrel rotator between two requesters. A granted command is
// registered onto the rot_* ports for one SHIFT cycle. The rotator result is
// then captured and held as a response until the consumer accepts it.
module rot_arbiter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic [2:0] req0_amt,
   input  logic       req0_lr,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic [2:0] req1_amt,
   input  logic       req1_lr,
   output logic       req1_ready,
   output logic [7:0] rot_a,
   output logic [2:0] rot_amt,
   output logic       rot_lr,
   input  logic [7:0] rot_y,
   output logic       resp_valid,
   output logic       resp_id,
   output logic [7:0] resp_data,
   input  logic       resp_ready,
   output logic       busy,
   output logic [7:0] done_cnt
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0] r_state;
   logic       r_prio;
   logic [7:0] r_rot_a;
   logic [2:0] r_rot_amt;
   logic       r_rot_lr;
   logic       r_resp_id;
   logic [7:0] r_resp_data;
   logic [7:0] r_done_cnt;

   logic       w_idle;
   logic       w_grant0;
   logic       w_grant1;
   logic       w_resp_fire;

   // Grant only in IDLE and outside reset. A lone valid wins outright;
   // when both are valid, the priority pointer decides.
   assign w_idle      = (r_state == S_IDLE) && reset_n;
   assign w_grant0    = w_idle && req0_valid && (!req1_valid || !r_prio);
   assign w_grant1    = w_idle && req1_valid && (!req0_valid ||  r_prio);
   assign w_resp_fire = (r_state == S_RESP) && resp_ready;

   assign req0_ready = w_grant0;
   assign req1_ready = w_grant1;
   assign rot_a      = r_rot_a;
   assign rot_amt    = r_rot_amt;
   assign rot_lr     = r_rot_lr;
   assign resp_valid = (r_state == S_RESP);
   assign resp_id    = r_resp_id;
   assign resp_data  = r_resp_data;
   assign busy       = (r_state != S_IDLE);
   assign done_cnt   = r_done_cnt;

   // Sequencer: IDLE -> SHIFT on a grant, SHIFT -> RESP after one cycle,
   // RESP -> IDLE once the consumer takes the response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_grant0 || w_grant1) r_state <= S_SHIFT;
            S_SHIFT: r_state <= S_RESP;
            S_RESP:  if (resp_ready) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Latch the winner's operands and ID, and hand priority to the other side.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prio    <= 1'b0;
         r_rot_a   <= 8'd0;
         r_rot_amt <= 3'd0;
         r_rot_lr  <= 1'b0;
         r_resp_id <= 1'b0;
      end else if (w_grant0) begin
         r_prio    <= 1'b1;
         r_rot_a   <= req0_data;
         r_rot_amt <= req0_amt;
         r_rot_lr  <= req0_lr;
         r_resp_id <= 1'b0;
      end else if (w_grant1) begin
         r_prio    <= 1'b0;
         r_rot_a   <= req1_data;
         r_rot_amt <= req1_amt;
         r_rot_lr  <= req1_lr;
         r_resp_id <= 1'b1;
      end
   end

   // Capture the shared rotator's result at the end of the SHIFT cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_resp_data <= 8'd0;
      end else if (r_state == S_SHIFT) begin
         r_resp_data <= rot_y;
      end
   end

   // Count accepted responses; wraps silently at 255.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done_cnt <= 8'd0;
      end else if (w_resp_fire) begin
         r_done_cnt <= r_done_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_rot_arbiter.sv
// tb_rot_arbiter: directed stimulus with hand-computed results. Expected
// responses go into a queue when a command is accepted. A separate monitor
// pops the queue and compares each response the DUT hands over.
module tb_rot_arbiter;

   logic       clk;
   logic       reset_n;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic [2:0] req0_amt;
   logic       req0_lr;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic [2:0] req1_amt;
   logic       req1_lr;
   logic       req1_ready;
   logic [7:0] rot_a;
   logic [2:0] rot_amt;
   logic       rot_lr;
   logic [7:0] rot_y;
   logic       resp_valid;
   logic       resp_id;
   logic [7:0] resp_data;
   logic       resp_ready;
   logic       busy;
   logic [7:0] done_cnt;

   int checks;
   int errors;
   logic [8:0] expQ[$];

   rot_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_amt(req0_amt),
      .req0_lr(req0_lr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_amt(req1_amt),
      .req1_lr(req1_lr), .req1_ready(req1_ready),
      .rot_a(rot_a), .rot_amt(rot_amt), .rot_lr(rot_lr), .rot_y(rot_y),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
      .resp_ready(resp_ready), .busy(busy), .done_cnt(done_cnt)
   );

   // Reference rotator: one bit position per step.
   function automatic logic [7:0] rotModel(input logic [7:0] a, input logic [2:0] k,
                                           input logic left);
      logic [7:0] v;
      v = a;
      for (int i = 0; i < int'(k); i++) begin
         if (left) v = {v[6:0], v[7]};
         else      v = {v[0], v[7:1]};
      end
      return v;
   endfunction

   assign rot_y = rotModel(rot_a, rot_amt, rot_lr);

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: on each response handshake, compare against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (resp_valid && resp_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_resp", {23'd0, resp_id, resp_data}, 32'h1ff);
            end else begin
               logic [8:0] e;
               e = expQ.pop_front();
               checkOutput("resp_id", {31'd0, resp_id}, {31'd0, e[8]});
               checkOutput("resp_data", {24'd0, resp_data}, {24'd0, e[7:0]});
            end
         end
      end
   end

   // Present one command from requester id, wait (bounded) for its ready,
   // queue the expected result, then drop valid after the accepting edge.
   task automatic applyStimulus(input logic id, input logic [7:0] data,
                                input logic [2:0] amt, input logic lr,
                                input logic [7:0] expData);
      bit got;
      got = 0;
      if (id) begin
         req1_valid = 1'b1; req1_data = data; req1_amt = amt; req1_lr = lr;
      end else begin
         req0_valid = 1'b1; req0_data = data; req0_amt = amt; req0_lr = lr;
      end
      for (int c = 0; c < 20 && !got; c++) begin
         @(negedge clk);
         if ((id ? req1_ready : req0_ready) === 1'b1) begin
            expQ.push_back({id, expData});
            got = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!got) begin
         errors++;
         $display("[TB] FAIL accept_timeout: id %0d not granted, expected grant", id);
      end
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   // Wait (bounded) until all queued responses are consumed and the DUT is idle.
   task automatic waitDrain();
      bit ok;
      ok = 0;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk);
         if (expQ.size() == 0 && busy === 1'b0) ok = 1;
      end
      if (!ok) begin
         errors++;
         $display("[TB] FAIL drain_timeout: %0d pending, expected 0", expQ.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      logic [7:0] savedCnt;
      int grants;
      logic expGrant;

      checks = 0;
      errors = 0;
      reset_n = 1'b0;
      req0_valid = 1'b1; req0_data = 8'h00; req0_amt = 3'd0; req0_lr = 1'b0;
      req1_valid = 1'b1; req1_data = 8'h00; req1_amt = 3'd0; req1_lr = 1'b0;
      resp_ready = 1'b0;

      // Reset state, with both valids held to prove readies stay low.
      repeat (2) @(negedge clk);
      checkOutput("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      checkOutput("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      checkOutput("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done_cnt", {24'd0, done_cnt}, 32'd0);
      checkOutput("rst_rot", {20'd0, rot_a, rot_amt, rot_lr}, 32'd0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      resp_ready = 1'b1;

      // Single command with cycle-exact latency checks.
      @(posedge clk);
      #1;
      req0_valid = 1'b1; req0_data = 8'hB4; req0_amt = 3'd3; req0_lr = 1'b1;
      @(negedge clk);
      checkOutput("single_req0_ready", {31'd0, req0_ready}, 32'd1);
      checkOutput("single_req1_ready", {31'd0, req1_ready}, 32'd0);
      expQ.push_back({1'b0, 8'hA5});
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      @(negedge clk);
      checkOutput("shift_rot", {20'd0, rot_a, rot_amt, rot_lr}, {20'd0, 8'hB4, 3'd3, 1'b1});
      checkOutput("shift_busy", {31'd0, busy}, 32'd1);
      checkOutput("shift_resp_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      checkOutput("resp_valid_n2", {31'd0, resp_valid}, 32'd1);
      @(negedge clk);
      checkOutput("single_done_cnt", {24'd0, done_cnt}, 32'd1);
      checkOutput("single_idle", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;

      // Right rotation, then amount zero pass-through.
      applyStimulus(1'b1, 8'h01, 3'd1, 1'b0, 8'h80);
      waitDrain();
      applyStimulus(1'b1, 8'h5A, 3'd0, 1'b1, 8'h5A);
      waitDrain();
      checkOutput("done_cnt_3", {24'd0, done_cnt}, 32'd3);

      // Contention after reset: grants must alternate starting with req0.
      pulseReset();
      req0_valid = 1'b1; req0_data = 8'h0F; req0_amt = 3'd4; req0_lr = 1'b1;
      req1_valid = 1'b1; req1_data = 8'h81; req1_amt = 3'd1; req1_lr = 1'b0;
      grants = 0;
      expGrant = 1'b0;
      for (int c = 0; c < 40 && grants < 4; c++) begin
         @(negedge clk);
         if (req0_ready === 1'b1 && req1_ready === 1'b1) begin
            checkOutput("double_grant", 32'd2, 32'd1);
         end else if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
            checkOutput("grant_order", {31'd0, req1_ready}, {31'd0, expGrant});
            if (req1_ready) expQ.push_back({1'b1, 8'hC0});
            else            expQ.push_back({1'b0, 8'hF0});
            expGrant = ~expGrant;
            grants++;
         end
         @(posedge clk);
         #1;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (grants != 4) begin
         errors++;
         $display("[TB] FAIL contention_grants: got %0d, expected 4", grants);
      end
      waitDrain();

      // Backpressure: stall in RESP for 5 cycles with a competing valid.
      resp_ready = 1'b0;
      savedCnt = done_cnt;
      applyStimulus(1'b0, 8'h3C, 3'd2, 1'b0, 8'h0F);
      @(negedge clk);
      req1_valid = 1'b1; req1_data = 8'h11; req1_amt = 3'd1; req1_lr = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
         checkOutput("bp_resp_data", {24'd0, resp_data}, 32'h0F);
         checkOutput("bp_resp_id", {31'd0, resp_id}, 32'd0);
         checkOutput("bp_readies", {30'd0, req1_ready, req0_ready}, 32'd0);
         checkOutput("bp_done_cnt", {24'd0, done_cnt}, {24'd0, savedCnt});
      end
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      resp_ready = 1'b1;
      waitDrain();
      checkOutput("bp_done_cnt_after", {24'd0, done_cnt}, {24'd0, savedCnt + 8'd1});

      // Reset during SHIFT discards the in-flight command.
      applyStimulus(1'b1, 8'hC3, 3'd5, 1'b1, 8'h78);
      reset_n = 1'b0;
      #1;
      checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      checkOutput("mid_rst_done_cnt", {24'd0, done_cnt}, 32'd0);
      checkOutput("mid_rst_rot", {20'd0, rot_a, rot_amt, rot_lr}, 32'd0);
      checkOutput("mid_rst_resp_data", {24'd0, resp_data}, 32'd0);
      expQ.delete();
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checkOutput("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      checkOutput("post_rst_done_cnt", {24'd0, done_cnt}, 32'd0);
      @(posedge clk);
      #1;

      // 256 back-to-back commands: counter wraps to zero.
      for (int i = 0; i < 256; i++) begin
         logic [7:0] d;
         logic [2:0] k;
         logic       l;
         d = 8'(i) ^ 8'hA5;
         k = 3'(i % 8);
         l = (i % 16) >= 8;
         applyStimulus(1'(i % 2), d, k, l, rotModel(d, k, l));
      end
      waitDrain();
      checkOutput("wrap_done_cnt", {24'd0, done_cnt}, 32'd0);
      checkOutput("final_queue_empty", expQ.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
